// File: rtl/l1icache_param.sv
// l1icache_param: parametrised direct-mapped L1 instruction cache.
// This block sits between the fetch stage and a Wishbone burst bus.
// Tags and data live in external single-port SRAM macros with active-low
// enables. Line validity is kept in flops, so a flush or reset empties the
// cache in a single cycle.
module l1icache_param #(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 2,
    localparam int IDX_W     = $clog2(SETS),
    localparam int WOFF_W    = $clog2(LINE_WORDS),
    localparam int OFF_W     = WOFF_W + 2,
    localparam int TAG_W     = ADDR_W - IDX_W - OFF_W
) (
    input  logic                    clk,
    input  logic                    rstn,
    // fetch request
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_W-1:0]       req_addr_i,
    // fetch response
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [31:0]             resp_data_o,
    output logic [ADDR_W-1:0]       resp_addr_o,
    // fence.i
    input  logic                    flush_i,
    // tag SRAM
    output logic                    tag_cen_o,
    output logic                    tag_wen_o,
    output logic [IDX_W-1:0]        tag_idx_o,
    output logic [TAG_W-1:0]        tag_din_o,
    input  logic [TAG_W-1:0]        tag_dout_i,
    // data SRAM
    output logic                    data_cen_o,
    output logic                    data_wen_o,
    output logic [IDX_W+WOFF_W-1:0] data_idx_o,
    output logic [31:0]             data_din_o,
    input  logic [31:0]             data_dout_i,
    // Wishbone master
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_W-1:0]       wb_adr_o,
    output logic [9:0]              wb_bl_o,
    input  logic                    wb_ack_i,
    input  logic [31:0]             wb_dat_i,
    // performance counters
    output logic [31:0]             perf_hit_o,
    output logic [31:0]             perf_miss_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_REFILL = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(LINE_WORDS - 1);

    state_t              state_q, state_d;
    logic [SETS-1:0]     valid_q, valid_d;
    logic                flush_pend_q, flush_pend_d;
    logic [WOFF_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic [31:0]         perf_hit_q, perf_hit_d;
    logic [31:0]         perf_miss_q, perf_miss_d;

    // Address fields of the incoming request and of the saved request.
    logic [IDX_W-1:0]    req_idx_s;
    logic [WOFF_W-1:0]   req_word_s;
    logic [TAG_W-1:0]    sv_tag_s;
    logic [IDX_W-1:0]    sv_idx_s;
    logic [WOFF_W-1:0]   sv_word_s;
    logic                hit_s;

    assign req_idx_s  = req_addr_i[OFF_W+IDX_W-1:OFF_W];
    assign req_word_s = req_addr_i[OFF_W-1:2];
    assign sv_tag_s   = addr_q[ADDR_W-1:OFF_W+IDX_W];
    assign sv_idx_s   = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign sv_word_s  = addr_q[OFF_W-1:2];
    assign hit_s      = valid_q[sv_idx_s] & (tag_dout_i == sv_tag_s);

    // Outputs that are either held in flops or are fixed.
    assign resp_data_o = resp_data_q;
    assign resp_addr_o = addr_q;
    assign perf_hit_o  = perf_hit_q;
    assign perf_miss_o = perf_miss_q;
    assign wb_stb_o    = wb_cyc_o;
    assign wb_we_o     = 1'b0;
    assign wb_adr_o    = {sv_tag_s, sv_idx_s, beat_q, 2'b00};
    assign wb_bl_o     = wb_cyc_o ? 10'(LINE_WORDS - 1) : 10'd0;
    assign tag_din_o   = sv_tag_s;
    assign data_din_o  = wb_dat_i;

    // Next-state, SRAM strobes and handshake decode for the cache controller.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        beat_d       = beat_q;
        addr_d       = addr_q;
        resp_data_d  = resp_data_q;
        perf_hit_d   = perf_hit_q;
        perf_miss_d  = perf_miss_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        wb_cyc_o     = 1'b0;
        tag_cen_o    = 1'b1;
        tag_wen_o    = 1'b1;
        tag_idx_o    = sv_idx_s;
        data_cen_o   = 1'b1;
        data_wen_o   = 1'b1;
        data_idx_o   = {sv_idx_s, beat_q};

        // A flush that arrives while busy is remembered and applied in IDLE,
        // so it also wipes the line being filled right now.
        if ((state_q != S_IDLE) && flush_i) begin
            flush_pend_d = 1'b1;
        end else begin
            flush_pend_d = flush_pend_d;
        end

        case (state_q)
            S_IDLE: begin
                req_ready_o = ~flush_i & ~flush_pend_q;
                if (flush_i | flush_pend_q) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end else if (req_valid_i) begin
                    addr_d     = req_addr_i;
                    tag_cen_o  = 1'b0;
                    tag_idx_o  = req_idx_s;
                    data_cen_o = 1'b0;
                    data_idx_o = {req_idx_s, req_word_s};
                    state_d    = S_LOOKUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: begin
                if (hit_s) begin
                    resp_data_d = data_dout_i;
                    perf_hit_d  = perf_hit_q + 32'd1;
                    state_d     = S_RESP;
                end else begin
                    perf_miss_d = perf_miss_q + 32'd1;
                    beat_d      = '0;
                    state_d     = S_REFILL;
                end
            end
            S_REFILL: begin
                wb_cyc_o = 1'b1;
                if (wb_ack_i) begin
                    data_cen_o = 1'b0;
                    data_wen_o = 1'b0;
                    beat_d     = beat_q + WOFF_W'(1);
                    if (beat_q == sv_word_s) begin
                        resp_data_d = wb_dat_i;
                    end else begin
                        resp_data_d = resp_data_q;
                    end
                    if (beat_q == LAST_BEAT) begin
                        tag_cen_o         = 1'b0;
                        tag_wen_o         = 1'b0;
                        valid_d[sv_idx_s] = 1'b1;
                        state_d           = S_RESP;
                    end else begin
                        state_d = S_REFILL;
                    end
                end else begin
                    state_d = S_REFILL;
                end
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            beat_q       <= '0;
            addr_q       <= '0;
            resp_data_q  <= 32'd0;
            perf_hit_q   <= 32'd0;
            perf_miss_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            beat_q       <= beat_d;
            addr_q       <= addr_d;
            resp_data_q  <= resp_data_d;
            perf_hit_q   <= perf_hit_d;
            perf_miss_q  <= perf_miss_d;
        end
    end

endmodule
